// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set LRU
// replacement, internal tag/data register arrays and hit/miss statistics counters.
module dcache_2way #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int SET_BITS = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int TAG_W  = ADDR_W - SET_BITS - OFF_W;
    localparam int SETS   = 1 << SET_BITS;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0] data_q  [2][SETS];
    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   lru_q;

    // Miss context is latched so the memory transaction completes even if the CPU drops its request.
    logic                victim_q;
    logic [SET_BITS-1:0] miss_idx_q;
    logic [TAG_W-1:0]    miss_tag_q;

    logic [TAG_W-1:0]    req_tag;
    logic [SET_BITS-1:0] req_idx;
    logic [WSEL_W-1:0]   word_sel;
    logic [1:0]          way_hit;
    logic                req;
    logic                idle;
    logic                hit;
    logic                miss;
    logic                hit_way;
    logic                victim_sel;
    logic                victim_dirty;
    logic                wb_ack;
    logic                fill_ack;
    logic                addr_unused;

    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx     = p1_addr_i[OFF_W +: SET_BITS];
    assign word_sel    = p1_addr_i[2 +: WSEL_W];
    assign addr_unused = &{1'b0, p1_addr_i[1:0]};

    assign req  = p1_MemRead_i | p1_MemWrite_i;
    assign idle = (state_q == IDLE);

    assign way_hit[0] = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign way_hit[1] = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);

    assign hit        = req && idle && (|way_hit);
    assign miss       = req && idle && !(|way_hit);
    assign hit_way    = !way_hit[0];
    assign p1_stall_o = req && !hit;
    assign p1_data_o  = hit ? data_q[hit_way][req_idx][{word_sel, 5'b0} +: 32] : 32'd0;

    // Invalid way0 first, then invalid way1, otherwise the LRU way.
    assign victim_sel   = valid_q[0][req_idx] && (!valid_q[1][req_idx] || lru_q[req_idx]);
    assign victim_dirty = valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx];

    assign wb_ack   = (state_q == WRITEBACK) && mem_ack_i;
    assign fill_ack = (state_q == ALLOCATE) && mem_ack_i;

    assign mem_data_o = data_q[victim_q][miss_idx_q];

    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[victim_q][miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
            victim_q   <= 1'b0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            if (hit) begin
                lru_q[req_idx] <= !hit_way;
                hit_cnt_o      <= hit_cnt_o + CNT_W'(1);
                if (p1_MemWrite_i) begin
                    dirty_q[hit_way][req_idx] <= 1'b1;
                end
            end
            if (miss) begin
                victim_q   <= victim_sel;
                miss_idx_q <= req_idx;
                miss_tag_q <= req_tag;
                miss_cnt_o <= miss_cnt_o + CNT_W'(1);
            end
            if (wb_ack) begin
                dirty_q[victim_q][miss_idx_q] <= 1'b0;
            end
            if (fill_ack) begin
                valid_q[victim_q][miss_idx_q] <= 1'b1;
                dirty_q[victim_q][miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; validity alone decides whether contents are used.
    always_ff @(posedge clk_i) begin
        if (hit && p1_MemWrite_i) begin
            data_q[hit_way][req_idx][{word_sel, 5'b0} +: 32] <= p1_data_i;
        end
        if (fill_ack) begin
            data_q[victim_q][miss_idx_q] <= mem_data_i;
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_dcache_2way.sv
// Self-checking bench for dcache_2way: directed scenarios then random accesses,
// compared against a set/way reference model and a line-granular memory model.
module tb_dcache_2way;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int SET_BITS = 4;
    localparam int CNT_W    = 16;
    localparam int SETS     = 16;
    localparam int LW       = LINE_W;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [ADDR_W-1:0] p1_addr_i = '0;
    logic [31:0]       p1_data_i = '0;
    logic              p1_MemRead_i = 1'b0;
    logic              p1_MemWrite_i = 1'b0;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic              mem_ack_i = 1'b0;
    logic [CNT_W-1:0]  hit_cnt_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    dcache_2way #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .SET_BITS(SET_BITS), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: per set, two ways of {valid, dirty, tag, line} and the way to evict next.
    logic              mValid [SETS][2];
    logic              mDirty [SETS][2];
    int unsigned       mTag   [SETS][2];
    logic [LINE_W-1:0] mData  [SETS][2];
    int                mLru   [SETS];
    logic [LINE_W-1:0] memStore [int unsigned];
    int unsigned       expHits;
    int unsigned       expMisses;

    task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int s = 0; s < SETS; s++) begin
            mValid[s][0] = 1'b0;
            mValid[s][1] = 1'b0;
            mDirty[s][0] = 1'b0;
            mDirty[s][1] = 1'b0;
            mLru[s]      = 0;
        end
        expHits   = 0;
        expMisses = 0;
    endtask

    task automatic fetchLine(input int unsigned la, output logic [LW-1:0] line);
        if (!memStore.exists(la)) begin
            for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
            memStore[la] = line;
        end
        line = memStore[la];
    endtask

    task automatic memHandshake(input bit expWrite, input logic [31:0] expAddr,
                                input logic [LW-1:0] expData, input int delay,
                                input logic [LW-1:0] fillData);
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk_i);
            #1;
            checkOutput("mem_enable", LW'(mem_enable_o), LW'(1'b1));
            checkOutput("mem_write", LW'(mem_write_o), LW'(expWrite));
            checkOutput("mem_addr", LW'(mem_addr_o), LW'(expAddr));
            if (expWrite) checkOutput("mem_data", mem_data_o, expData);
            checkOutput("mem_stall", LW'(p1_stall_o), LW'(1'b1));
            if (c == delay) begin
                mem_ack_i  = 1'b1;
                mem_data_i = fillData;
            end
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
        end
    endtask

    // One complete CPU access, including any write-back/allocate handshake.
    task automatic applyStimulus(input logic [31:0] addr, input bit doRead, input bit doWrite,
                                 input logic [31:0] wdata, input int wbDelay, input int allocDelay);
        int unsigned idx, tg, wd, la, va;
        int w, v;
        logic [LW-1:0] line;
        idx = (addr >> 5) & 15;
        tg  = addr >> 9;
        wd  = (addr >> 2) & 7;
        la  = addr & ~32'h1F;
        @(negedge clk_i);
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemRead_i  = doRead;
        p1_MemWrite_i = doWrite;
        #1;
        w = -1;
        for (int k = 0; k < 2; k++) if (w < 0 && mValid[idx][k] && mTag[idx][k] == tg) w = k;
        if (w < 0) begin
            checkOutput("miss_stall", LW'(p1_stall_o), LW'(1'b1));
            checkOutput("miss_data", LW'(p1_data_o), LW'(32'd0));
            checkOutput("miss_mem_idle", LW'(mem_enable_o), LW'(1'b0));
            v = !mValid[idx][0] ? 0 : (!mValid[idx][1] ? 1 : mLru[idx]);
            expMisses++;
            @(posedge clk_i);
            if (mValid[idx][v] && mDirty[idx][v]) begin
                va = (mTag[idx][v] << 9) | (idx << 5);
                memHandshake(1'b1, va, mData[idx][v], wbDelay, '0);
                memStore[va] = mData[idx][v];
            end
            fetchLine(la, line);
            memHandshake(1'b0, la, '0, allocDelay, line);
            mValid[idx][v] = 1'b1;
            mDirty[idx][v] = 1'b0;
            mTag[idx][v]   = tg;
            mData[idx][v]  = line;
            @(negedge clk_i);
            #1;
            checkOutput("fill_stall", LW'(p1_stall_o), LW'(1'b1));
            checkOutput("fill_mem", LW'(mem_enable_o), LW'(1'b0));
            @(negedge clk_i);
            #1;
            w = v;
        end
        checkOutput("hit_stall", LW'(p1_stall_o), LW'(1'b0));
        checkOutput("hit_mem", LW'(mem_enable_o), LW'(1'b0));
        if (!doWrite) checkOutput("hit_data", LW'(p1_data_o), LW'(mData[idx][w][wd*32 +: 32]));
        @(posedge clk_i);
        expHits++;
        mLru[idx] = 1 - w;
        if (doWrite) begin
            mData[idx][w][wd*32 +: 32] = wdata;
            mDirty[idx][w] = 1'b1;
        end
        @(negedge clk_i);
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        #1;
        checkOutput("hit_cnt", LW'(hit_cnt_o), LW'(expHits[CNT_W-1:0]));
        checkOutput("miss_cnt", LW'(miss_cnt_o), LW'(expMisses[CNT_W-1:0]));
    endtask

    // Look at a resident word without letting the request reach a clock edge.
    task automatic probeRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk_i);
        p1_addr_i     = addr;
        p1_MemRead_i  = 1'b1;
        p1_MemWrite_i = 1'b0;
        #1;
        checkOutput({tag, "_stall"}, LW'(p1_stall_o), LW'(1'b0));
        checkOutput(tag, LW'(p1_data_o), LW'(exp));
        #1;
        p1_MemRead_i = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] line;
        logic [31:0]   addr;
        bit            wr;

        resetModel();
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("rst_mem_enable", LW'(mem_enable_o), LW'(1'b0));
        checkOutput("rst_mem_write", LW'(mem_write_o), LW'(1'b0));
        checkOutput("rst_stall", LW'(p1_stall_o), LW'(1'b0));
        checkOutput("rst_hit_cnt", LW'(hit_cnt_o), LW'(16'd0));
        checkOutput("rst_miss_cnt", LW'(miss_cnt_o), LW'(16'd0));
        rst_i = 1'b1;

        $display("[TB] cold read with word2 = DEADBEEF");
        for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
        line[95:64] = 32'hDEADBEEF;
        memStore[32'h40] = line;
        applyStimulus(32'h040, 1'b1, 1'b0, 32'd0, 0, 1);
        probeRead("cold_word2", 32'h048, 32'hDEADBEEF);
        checkOutput("cold_miss_cnt", LW'(miss_cnt_o), LW'(16'd1));

        $display("[TB] write hit then readback");
        applyStimulus(32'h044, 1'b0, 1'b1, 32'h12345678, 0, 0);
        probeRead("wr_readback", 32'h044, 32'h12345678);

        $display("[TB] clean conflict in set 2");
        applyStimulus(32'h240, 1'b1, 1'b0, 32'd0, 0, 0);
        applyStimulus(32'h040, 1'b1, 1'b0, 32'd0, 0, 0);
        applyStimulus(32'h440, 1'b1, 1'b0, 32'd0, 0, 2);
        probeRead("keep_0x040", 32'h044, 32'h12345678);

        $display("[TB] dirty eviction of 0x440");
        applyStimulus(32'h440, 1'b0, 1'b1, 32'hCAFEF00D, 0, 0);
        applyStimulus(32'h040, 1'b1, 1'b0, 32'd0, 0, 0);
        applyStimulus(32'h240, 1'b1, 1'b0, 32'd0, 2, 1);

        $display("[TB] slow memory and stray ack");
        applyStimulus(32'h1000, 1'b1, 1'b0, 32'd0, 0, 10);
        @(negedge clk_i);
        mem_ack_i  = 1'b1;
        mem_data_i = {8{$urandom}};
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        #1;
        checkOutput("stray_mem_enable", LW'(mem_enable_o), LW'(1'b0));
        checkOutput("stray_miss_cnt", LW'(miss_cnt_o), LW'(expMisses[CNT_W-1:0]));
        probeRead("stray_keep", 32'h1000, mData[0][mTag[0][0] == 32'h8 ? 0 : 1][31:0]);

        $display("[TB] reset during write-back");
        @(negedge clk_i);
        p1_addr_i    = 32'h640;
        p1_MemRead_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checkOutput("wb_enable", LW'(mem_enable_o), LW'(1'b1));
        checkOutput("wb_write", LW'(mem_write_o), LW'(1'b1));
        checkOutput("wb_addr", LW'(mem_addr_o), LW'(32'h040));
        rst_i = 1'b0;
        #1;
        checkOutput("midrst_enable", LW'(mem_enable_o), LW'(1'b0));
        checkOutput("midrst_write", LW'(mem_write_o), LW'(1'b0));
        checkOutput("midrst_hit_cnt", LW'(hit_cnt_o), LW'(16'd0));
        checkOutput("midrst_miss_cnt", LW'(miss_cnt_o), LW'(16'd0));
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        resetModel();
        applyStimulus(32'h040, 1'b1, 1'b0, 32'd0, 0, 0);
        checkOutput("post_rst_miss_cnt", LW'(miss_cnt_o), LW'(16'd1));

        $display("[TB] random accesses");
        for (int n = 0; n < 200; n++) begin
            addr = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            wr   = bit'($urandom_range(0, 1));
            applyStimulus(addr, wr ? bit'($urandom_range(0, 1)) : 1'b1, wr, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dcache_2way.md
Name: dcache_2way

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU load/store port and the 256-bit-line data memory.
- Successor to the direct-mapped data cache:
  - line width and set count are parameters;
  - replacement is LRU per set;
  - tag/data storage is internal (register arrays, read combinationally);
  - hit/miss statistics counters are added.
- The CPU stalls on a miss until the line is resident.

Parameters:
ADDR_W, 32, CPU/memory byte-address width
LINE_W, 256, cache line width in bits (power of two, multiple of 32, at least 64)
SET_BITS, 4, log2 of set count (default 16 sets x 2 ways = 32 lines)
CNT_W, 16, width of statistics counters
(derived) OFF_W = log2(LINE_W/8); TAG_W = ADDR_W - SET_BITS - OFF_W

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
p1_addr_i  in  ADDR_W  CPU byte address; bits [1:0] ignored
p1_data_i  in  32  CPU write data
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request (wins if both requests are high)
p1_data_o  out  32  load data, combinational on hit
p1_stall_o  out  1  request pending and not hit
mem_enable_o  out  1  memory request valid
mem_write_o  out  1  1 = write-back, 0 = line read
mem_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits = 0)
mem_data_o  out  LINE_W  victim line for write-back
mem_data_i  in  LINE_W  fill data
mem_ack_i  in  1  memory completion, single-cycle pulse
hit_cnt_o  out  CNT_W  hits counted
miss_cnt_o  out  CNT_W  misses counted

Behaviour:
- Address split:
  - offset = addr[OFF_W-1:0]
  - word select = offset[OFF_W-1:2]
  - index = addr[OFF_W+SET_BITS-1:OFF_W]
  - tag = upper TAG_W bits
- Per-line state: valid, dirty, tag, data. Per-set state: lru bit (the way to evict next).
- Hit (combinational) = request AND state IDLE AND some way w has valid and a matching tag.
- p1_stall_o = request AND NOT hit. Stall is high from the first cycle of a miss.
- Read hit:
  - p1_data_o = selected 32-bit word of the hitting way, same cycle.
  - At the clock edge, lru <= other way.
  - p1_data_o = 0 when not hit.
- Write hit: at the clock edge the selected word is replaced with p1_data_i, dirty <= 1, and lru <= other way.
- CPU holds address, data and request stable while stalled.
- Victim selection at miss detection:
  - first invalid way, way0 preferred;
  - otherwise the way indicated by lru.
  - The victim is latched for the duration of the miss.
- FSM states: IDLE, WRITEBACK, ALLOCATE, FILL.
  - IDLE:
    - miss with a valid, dirty victim -> WRITEBACK;
    - miss with a clean or invalid victim -> ALLOCATE.
    - miss_cnt increments once on this transition.
  - WRITEBACK:
    - mem_enable_o = 1, mem_write_o = 1;
    - mem_addr_o = {victim tag, index, 0};
    - mem_data_o = victim line.
    - On mem_ack_i: clear the victim's dirty bit, go to ALLOCATE.
  - ALLOCATE:
    - mem_enable_o = 1, mem_write_o = 0;
    - mem_addr_o = {req tag, index, 0}.
    - On mem_ack_i: write mem_data_i, tag, valid = 1, dirty = 0 into the victim way; go to FILL.
  - FILL: one bubble cycle, no memory request -> IDLE. The request then hits normally (a store merges as a write hit).
- Memory outputs:
  - mem_enable_o, mem_write_o and mem_addr_o are decoded from the registered state and held stable until ack.
  - mem_data_o is don't-care outside WRITEBACK.
  - mem_ack_i is ignored in IDLE and FILL.
- Counters:
  - hit_cnt increments on every clock edge with a hit, including the post-fill hit.
  - Both counters wrap modulo 2^CNT_W.
- Minimum miss latency (clean victim, ack in the first memory cycle): 3 stall cycles. Dirty victim adds one cycle per write-back handshake cycle.
- Reset (asynchronous, any state, including mid-write-back or mid-fill):
  - state IDLE;
  - mem_enable_o = 0, mem_write_o = 0;
  - all valid, dirty and lru bits 0; counters 0.
  - Data and tag arrays are not reset.
  - An interrupted fill leaves its line invalid.
- Request dropped while in WRITEBACK or ALLOCATE: the transaction still completes (line installed); the FSM returns to IDLE.

Test Plan:
- Cold read 0x040 after reset; memory acks on the 2nd ALLOCATE cycle with word2 = 0xDEADBEEF.
  -> stall high; mem_enable_o = 1, mem_write_o = 0, mem_addr_o = 0x040.
  -> Then read 0x048 returns 0xDEADBEEF with no stall; miss_cnt = 1.
- Write 0x12345678 to 0x044 after the fill.
  -> no stall, no memory request.
  -> Read 0x044 returns 0x12345678; the line is dirty.
- Conflict on set 2 (clean lines):
  - Read 0x240 -> fills way1 (way0 holds 0x040, written back only if dirty).
  - Read 0x040 -> hit, lru -> way1.
  - Read 0x440 -> evicts way1 (0x240) with no WRITEBACK; 0x040 still hits.
- Dirty eviction:
  - Write 0xCAFEF00D to 0x440, read 0x040, then read 0x240.
  -> WRITEBACK to mem_addr_o = 0x440 with mem_data_o word0 = 0xCAFEF00D, then ALLOCATE at 0x240.
- Slow memory: hold mem_ack_i low for 10 cycles in ALLOCATE.
  -> stall, mem_enable_o and mem_addr_o stay constant.
  -> A stray ack pulse while IDLE has no effect.
- Assert rst_i low mid-WRITEBACK.
  -> mem_enable_o = 0 immediately; counters = 0.
  -> After release, read 0x040 misses again (cache invalidated).
